// File: rtl/sync_fifo_wr_arbiter_if.sv
// Producer handshake and FIFO write-port bundle for sync_fifo_wr_arbiter.
// Slave is the arbiter side; master is the producer/FIFO side.
interface sync_fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 1024
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic                          fifo_rd_i;
  logic                          fifo_wr_en_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic [CW-1:0]                 credit_o;
  logic                          err_o;

  modport master (
    output req_i, data_i, fifo_rd_i,
    input  gnt_o, fifo_wr_en_o, fifo_data_o, credit_o, err_o
  );

  modport slave (
    input  req_i, data_i, fifo_rd_i,
    output gnt_o, fifo_wr_en_o, fifo_data_o, credit_o, err_o
  );
endinterface

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin, credit-tracked write arbiter in front of one sync FIFO.
// Optional burst locking: define SYNC_FIFO_WR_ARB_BURST_EN.
module sync_fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 1024,
  parameter int MAX_BURST  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sync_fifo_wr_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  err_q, err_d;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_REQ-1:0]    gnt, rr_gnt;
  logic [PW-1:0]         win, rr_win;
  logic                  rr_hit, has_credit, rd_ok, xfer;

  assign has_credit = (credit_q != '0) && !rst_i;
  assign rd_ok      = bus.fifo_rd_i && (credit_q != FULL);

  // Walk far-to-near so the nearest requester after ptr_q wins.
  always_comb begin
    int idx;
    idx    = 0;
    rr_gnt = '0;
    rr_win = ptr_q;
    rr_hit = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (bus.req_i[idx]) begin
        rr_win = PW'(idx);
        rr_hit = 1'b1;
      end
    end
    rr_gnt[rr_win] = rr_hit;
  end

`ifdef SYNC_FIFO_WR_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, LOCK} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] own_q, own_d;
  logic [BW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    win     = rr_win;
    if (state_q == LOCK) begin
      win        = own_q;
      gnt[own_q] = bus.req_i[own_q] && has_credit;
    end else if (has_credit) begin
      gnt = rr_gnt;
    end
    xfer = |gnt;
    unique case (state_q)
      ARB: begin
        if (xfer) begin
          own_d = win;
          cnt_d = BW'(1);
          if (MAX_BURST > 1) state_d = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          cnt_d = cnt_q + BW'(1);
          if (cnt_d == BW'(MAX_BURST)) state_d = ARB;
        end else if (!bus.req_i[own_q]) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      own_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    gnt  = has_credit ? rr_gnt : '0;
    win  = rr_win;
    xfer = |gnt;
  end
`endif

  always_comb begin
    ptr_d    = xfer ? win : ptr_q;
    credit_d = credit_q - CW'(xfer) + CW'(rd_ok);
    err_d    = err_q | (bus.fifo_rd_i && (credit_q == FULL));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q    <= LAST;
      credit_q <= FULL;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      wr_q     <= xfer;
      if (xfer) data_q <= bus.data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.gnt_o        = gnt;
  assign bus.fifo_wr_en_o = wr_q;
  assign bus.fifo_data_o  = data_q;
  assign bus.credit_o     = credit_q;
  assign bus.err_o        = err_q;
endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Randomized bench: two arbiters (deep and 4-slot FIFO) driven in lockstep
// and compared every cycle against a queue-free behavioural model.
module tb_sync_fifo_wr_arbiter;
  localparam int DW = 64;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int DA = 1024;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .FIFO_DEPTH(DA)) bus_a ();
  sync_fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .FIFO_DEPTH(DB)) bus_b ();

  sync_fifo_wr_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .FIFO_DEPTH(DA), .MAX_BURST(MB)
  ) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));

  sync_fifo_wr_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .FIFO_DEPTH(DB), .MAX_BURST(MB)
  ) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b.slave));

  logic [DW-1:0] words [NR];
  logic [NR-1:0] hold;
  int            m_credit [2];
  int            m_last   [2];
  int            m_owner  [2];
  int            m_cnt    [2];
  int            w_now    [2];
  bit            m_lock   [2];
  bit            m_err    [2];
  bit            e_wr     [2];
  logic [DW-1:0] e_data   [2];

  logic [NR-1:0] g_obs  [2];
  logic [NR-1:0] o_gnt  [2];
  logic          o_wr   [2];
  logic [DW-1:0] o_data [2];
  int            o_cred [2];
  logic          o_err  [2];

  function automatic int dep(int d);
    return (d == 0) ? DA : DB;
  endfunction

  function automatic int idx_of(logic [NR-1:0] g);
    for (int k = 0; k < NR; k++) if (g[k]) return k;
    return -1;
  endfunction

  // Winner for this cycle from the plain rules: credit, lock owner, rotation.
  function automatic int pick(int d, logic [NR-1:0] req);
    if (m_credit[d] == 0) return -1;
    if (m_lock[d]) return req[m_owner[d]] ? m_owner[d] : -1;
    for (int i = 1; i <= NR; i++) begin
      if (req[(m_last[d] + i) % NR]) return (m_last[d] + i) % NR;
    end
    return -1;
  endfunction

  function automatic void advance(int d, logic [NR-1:0] req, logic rd);
    bit xf;
    xf = (w_now[d] >= 0);
    e_wr[d] = xf;
    if (xf) begin
      e_data[d] = words[w_now[d]];
      m_last[d] = w_now[d];
    end
    if (rd && m_credit[d] == dep(d)) m_err[d] = 1'b1;
    else if (rd) m_credit[d]++;
    if (xf) m_credit[d]--;
`ifdef SYNC_FIFO_WR_ARB_BURST_EN
    if (m_lock[d]) begin
      if (xf) begin
        m_cnt[d]++;
        if (m_cnt[d] == MB) m_lock[d] = 1'b0;
      end else if (!req[m_owner[d]]) begin
        m_lock[d] = 1'b0;
      end
    end else if (xf) begin
      m_owner[d] = w_now[d];
      m_cnt[d]   = 1;
      m_lock[d]  = (MB > 1);
    end
`endif
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_credit[d] = dep(d);
      m_last[d]   = NR - 1;
      m_owner[d]  = 0;
      m_cnt[d]    = 0;
      m_lock[d]   = 1'b0;
      m_err[d]    = 1'b0;
      e_wr[d]     = 1'b0;
      e_data[d]   = '0;
    end
    hold = '0;
  endfunction

  task automatic sample();
    o_gnt[0]  = bus_a.gnt_o;
    o_wr[0]   = bus_a.fifo_wr_en_o;
    o_data[0] = bus_a.fifo_data_o;
    o_cred[0] = int'(bus_a.credit_o);
    o_err[0]  = bus_a.err_o;
    o_gnt[1]  = bus_b.gnt_o;
    o_wr[1]   = bus_b.fifo_wr_en_o;
    o_data[1] = bus_b.fifo_data_o;
    o_cred[1] = int'(bus_b.credit_o);
    o_err[1]  = bus_b.err_o;
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic rd);
    logic [NR*DW-1:0] flat;
    for (int k = 0; k < NR; k++) flat[k*DW +: DW] = words[k];
    bus_a.req_i = req;
    bus_a.data_i = flat;
    bus_a.fifo_rd_i = rd;
    bus_b.req_i = req;
    bus_b.data_i = flat;
    bus_b.fifo_rd_i = rd;
  endtask

  // One clock of stimulus; both DUTs scored against the model.
  task automatic cyc(input logic [NR-1:0] req, input logic rd);
    logic [NR-1:0] eg;
    @(negedge clk);
    for (int k = 0; k < NR; k++) if (!hold[k]) words[k] = {$urandom, $urandom};
    drive(req, rd);
    #1;
    sample();
    hold = '0;
    for (int d = 0; d < 2; d++) begin
      w_now[d] = pick(d, req);
      eg = '0;
      if (w_now[d] >= 0) eg[w_now[d]] = 1'b1;
      g_obs[d] = o_gnt[d];
      hold |= req & ~eg;
      checks++;
      if (o_gnt[d] !== eg) begin
        errors++;
        $display("FAIL gnt dut%0d: got %b want %b", d, o_gnt[d], eg);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) advance(d, req, rd);
    #1;
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_wr[d] !== e_wr[d]) begin
        errors++;
        $display("FAIL wr_en dut%0d: got %b want %b", d, o_wr[d], e_wr[d]);
      end
      if (e_wr[d]) begin
        checks++;
        if (o_data[d] !== e_data[d]) begin
          errors++;
          $display("FAIL data dut%0d: got %h want %h", d, o_data[d], e_data[d]);
        end
      end
      checks++;
      if (o_cred[d] !== m_credit[d]) begin
        errors++;
        $display("FAIL credit dut%0d: got %0d want %0d", d, o_cred[d], m_credit[d]);
      end
      checks++;
      if (o_err[d] !== m_err[d]) begin
        errors++;
        $display("FAIL err dut%0d: got %b want %b", d, o_err[d], m_err[d]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive('1, 1'b0);
    #1;
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_gnt[d] !== '0 || o_wr[d] !== 1'b0 || o_err[d] !== 1'b0 ||
          o_cred[d] !== dep(d)) begin
        errors++;
        $display("FAIL reset dut%0d: gnt=%b wr=%b err=%b credit=%0d want 0/0/0/%0d",
                 d, o_gnt[d], o_wr[d], o_err[d], o_cred[d], dep(d));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive('0, 1'b0);
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    cyc(4'b0010, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus_a.fifo_wr_en_o !== 1'b0 || bus_b.fifo_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_wr: got %b/%b want 0/0",
               bus_a.fifo_wr_en_o, bus_b.fifo_wr_en_o);
    end
    checks++;
    if (int'(bus_a.credit_o) !== DA) begin
      errors++;
      $display("FAIL async_rst_credit: got %0d want %0d", bus_a.credit_o, DA);
    end
    @(negedge clk);
    rst = 1'b0;
    drive('0, 1'b0);
    model_reset();
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(4'hF, 1'b0);
`ifdef SYNC_FIFO_WR_ARB_BURST_EN
      exp = i / 4;
`else
      exp = i % 4;
`endif
      checks++;
      if (idx_of(g_obs[0]) !== exp) begin
        errors++;
        $display("FAIL rr_order beat%0d: got %0d want %0d", i, idx_of(g_obs[0]), exp);
      end
    end
    checks++;
    if (int'(bus_a.credit_o) !== 1016) begin
      errors++;
      $display("FAIL rr_credit: got %0d want 1016", bus_a.credit_o);
    end
  endtask

  task automatic test_credit_exhaust();
    int n;
    do_reset();
    n = 0;
    repeat (6) begin
      cyc(4'b0100, 1'b0);
      n += int'(bus_b.fifo_wr_en_o);
    end
    checks++;
    if (n !== 4 || g_obs[1] !== '0 || int'(bus_b.credit_o) !== 0) begin
      errors++;
      $display("FAIL exhaust: writes=%0d gnt=%b credit=%0d want 4/0000/0",
               n, g_obs[1], bus_b.credit_o);
    end
    cyc(4'b0100, 1'b1);
    n = 0;
    repeat (3) begin
      cyc(4'b0100, 1'b0);
      n += int'(bus_b.fifo_wr_en_o);
    end
    checks++;
    if (n !== 1 || int'(bus_b.credit_o) !== 0) begin
      errors++;
      $display("FAIL refill: writes=%0d credit=%0d want 1/0", n, bus_b.credit_o);
    end
  endtask

  task automatic test_rd_with_xfer();
    do_reset();
    cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b1);
    checks++;
    if (int'(bus_b.credit_o) !== 3 || bus_b.fifo_wr_en_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_xfer: credit=%0d wr=%b want 3/1",
               bus_b.credit_o, bus_b.fifo_wr_en_o);
    end
    do_reset();
    cyc('0, 1'b1);
    repeat (3) cyc('0, 1'b0);
    checks++;
    if (int'(bus_b.credit_o) !== 4 || bus_b.err_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_full: credit=%0d err=%b want 4/1", bus_b.credit_o, bus_b.err_o);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    repeat (300) cyc(NR'($urandom), 1'($urandom_range(0, 3) == 0));
    repeat (300) cyc(NR'($urandom), 1'($urandom_range(0, 1)));
  endtask

`ifdef SYNC_FIFO_WR_ARB_BURST_EN
  task automatic test_burst();
    int got;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(4'b0011, 1'b0);
      checks++;
      if (idx_of(g_obs[0]) !== (i / 4) % 2) begin
        errors++;
        $display("FAIL burst_order beat%0d: got %0d want %0d",
                 i, idx_of(g_obs[0]), (i / 4) % 2);
      end
    end
    do_reset();
    cyc(4'b0011, 1'b0);
    cyc(4'b0011, 1'b0);
    got = -1;
    for (int i = 0; i < 4 && got < 0; i++) begin
      cyc(4'b0010, 1'b0);
      got = idx_of(g_obs[0]);
    end
    checks++;
    if (got !== 1) begin
      errors++;
      $display("FAIL burst_drop: got %0d want 1", got);
    end
  endtask

  task automatic test_burst_stall();
    do_reset();
    cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b0);
    cyc(4'b1001, 1'b0);
    checks++;
    if (g_obs[1] !== '0 || int'(bus_b.credit_o) !== 0) begin
      errors++;
      $display("FAIL stall: gnt=%b credit=%0d want 0000/0", g_obs[1], bus_b.credit_o);
    end
    cyc(4'b1001, 1'b1);
    cyc(4'b1001, 1'b0);
    checks++;
    if (g_obs[1] !== 4'b1000) begin
      errors++;
      $display("FAIL resume_owner: got %b want 1000", g_obs[1]);
    end
    cyc(4'b1001, 1'b1);
    cyc(4'b1001, 1'b0);
    cyc(4'b1001, 1'b1);
    cyc(4'b1001, 1'b0);
    checks++;
    if (g_obs[1] !== 4'b0001) begin
      errors++;
      $display("FAIL burst_exit: got %b want 0001", g_obs[1]);
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < NR; k++) words[k] = '0;
    model_reset();
    drive('0, 1'b0);
    test_reset();
    test_round_robin();
    test_credit_exhaust();
    test_rd_with_xfer();
`ifdef SYNC_FIFO_WR_ARB_BURST_EN
    test_burst();
    test_burst_stall();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_wr_arbiter.md
# sync_fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of one sync circular FIFO between NUM_REQ producers. Each producer uses a valid/ready handshake; the arbiter tracks free FIFO slots with a credit counter, so a granted write can never overflow the FIFO. The block sits directly in front of the FIFO, and its registered write outputs drive the FIFO write port.

## Interface
- DATA_WIDTH, 64, width of one data word
- NUM_REQ, 4, number of producers (2..16)
- FIFO_DEPTH, 1024, number of slots in the downstream FIFO; also the initial credit count
- MAX_BURST, 4, maximum consecutive beats per grant; used only with the burst feature
- clk_i  input  1  single clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- req_i  input  NUM_REQ  per-producer valid
- data_i  input  NUM_REQ*DATA_WIDTH  producer k word at bits [k*DATA_WIDTH +: DATA_WIDTH]
- gnt_o  output  NUM_REQ  per-producer ready; combinational, one-hot or zero
- fifo_rd_i  input  1  one-cycle pulse per word the FIFO consumer removes
- fifo_wr_en_o  output  1  registered write strobe to the FIFO
- fifo_data_o  output  DATA_WIDTH  registered write data
- credit_o  output  $clog2(FIFO_DEPTH+1)  current free-slot count
- err_o  output  1  sticky flag: fifo_rd_i seen while credit_o == FIFO_DEPTH

## Operation
- A beat from producer k transfers on the rising edge where req_i[k] and gnt_o[k] are both 1. The producer then drives its next word, or drops req_i, in the following cycle.
- Producers must hold data_i stable while req_i is high and gnt_o is low.
- At most one gnt_o bit is high. gnt_o is all zero while credit_o == 0 or rst_i is high.
- Round-robin state ptr_q holds the last granted index. Search order is ptr_q+1, ptr_q+2, … mod NUM_REQ, and the first asserted req_i wins. ptr_q updates to the winner on every transfer.
- Credit update each edge: credit = credit − transfer + (fifo_rd_i and credit < FIFO_DEPTH).
  - Transfer and read in the same cycle leave credit unchanged.
  - A read at full credit is ignored and sets err_o; only reset clears err_o.
- Credit arithmetic is unsigned at the width of credit_o, with no wrap in either direction.
- Reset values: ptr_q = NUM_REQ−1, so producer 0 has highest priority first. credit_o = FIFO_DEPTH, fifo_wr_en_o = 0, fifo_data_o = 0, err_o = 0, burst state = ARB.
- Reset asserted mid-burst or mid-write discards the pending registered write; fifo_wr_en_o drops immediately.

## Timing
- gnt_o is combinational from req_i, credit_o, ptr_q and the burst state, with zero latency.
- Write latency is 1 cycle: a transfer at edge N gives fifo_wr_en_o = 1 with that word on fifo_data_o during cycle N+1.
- Throughput is one word per cycle aggregate. A single producer with continuous req_i gets 1 beat/cycle when it is the only requester.
- credit_o reflects the transfer immediately after edge N, one cycle before the FIFO sees the write. This guarantees no overflow with no almost-full margin.
- With NUM_REQ producers all requesting, each producer is granted once every NUM_REQ cycles when the burst feature is not compiled.

## Configuration
- Macro: SYNC_FIFO_WR_ARB_BURST_EN.
- Without the macro:
  - No burst FSM; arbitration runs every cycle.
  - ptr_q rotates after every beat.
  - MAX_BURST is unused.
- With the macro, a two-state FSM is added, plus beat counter cnt_q of width $clog2(MAX_BURST+1).
  - ARB: a transfer to winner k sets owner = k and cnt_q = 1. If MAX_BURST > 1, the FSM moves to LOCK; otherwise it stays in ARB.
  - LOCK: gnt_o[owner] = req_i[owner] && credit_o != 0, and all other grants are 0. Each transfer increments cnt_q.
  - LOCK → ARB when req_i[owner] == 0, or when a transfer makes cnt_q == MAX_BURST.
  - credit_o == 0 in LOCK stalls the burst without leaving LOCK.
  - ptr_q = owner on exit.

## Test plan
- Reset, then idle: gnt_o = 0, fifo_wr_en_o = 0, credit_o = 1024, err_o = 0. Assert rst_i mid-write → fifo_wr_en_o = 0 asynchronously.
- req_i = 4'b1111, credit ample, no burst macro, 8 cycles → grants 0,1,2,3,0,1,2,3. fifo_data_o follows one cycle later; credit_o ends at 1016.
- FIFO_DEPTH = 4, only req_i[2] high, no reads → 4 writes, then gnt_o = 0 with credit_o = 0. One fifo_rd_i pulse → exactly one further write.
- Simultaneous transfer and fifo_rd_i at credit 3 → credit stays 3. fifo_rd_i at credit 4 with FIFO_DEPTH = 4 → credit stays 4 and err_o = 1 until reset.
- Burst macro, MAX_BURST = 4, req_i = 4'b0011 held → beats 0,0,0,0,1,1,1,1,0… Dropping req_i[0] after 2 beats → the next grant goes to producer 1.
- Burst macro, credit reaches 0 inside LOCK → gnt_o = 0 and the FSM stays in LOCK. The read pulse resumes the same owner, and cnt_q continues from its held value.
